// File: rtl/qbus_pkg.sv
// rtl/qbus_pkg.sv - shared types and constants for the QBUS DMA bus-master arbiter
//
// Purpose: state encoding, default DMGO timeout and requester-count limits
//          shared by qbus_dma_arb and qbus_arb_pick.
// Ports:   none (package).
package qbus_pkg;

  // Largest supported requester count; index fields are sized for it.
  localparam int NREQ_MAX    = 8;
  localparam int IDX_W       = $clog2(NREQ_MAX);

  // Cycles spent waiting for DMGO before a request is abandoned.
  localparam int TMO_DEFAULT = 255;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ACK  = 3'd2,
    OWN  = 3'd3,
    REL  = 3'd4
  } qbus_state_t;

endpackage

// File: rtl/qbus_arb_pick.sv
// rtl/qbus_arb_pick.sv - combinational rotating priority picker
//
// Purpose: returns a one-hot winner from req, searching upward from index
//          'start' and wrapping NREQ-1 to 0. start = 0 gives fixed priority
//          with index 0 highest.
// Ports:
//   req   in  NREQ   request vector
//   start in  IDX_W  index searched first (must be < NREQ)
//   win   out NREQ   one-hot winner, zero when req is zero
module qbus_arb_pick import qbus_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [NREQ-1:0]  win
);

  localparam logic [IDX_W:0]  NREQ_W = (IDX_W+1)'(NREQ);
  localparam logic [NREQ-1:0] ONE    = NREQ'(1);

  logic [IDX_W:0]  back_sh;
  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] low;

  // Rotate so 'start' lands on bit 0, isolate the lowest set bit, rotate back.
  // With start = 0 the shift by NREQ yields zero, so no special case is needed.
  assign back_sh = NREQ_W - {1'b0, start};
  assign rot     = (req >> start) | (req << back_sh);
  assign low     = rot & (~rot + ONE);
  assign win     = (low << start) | (low >> back_sh);

endmodule

// File: rtl/qbus_dma_arb.sv
// rtl/qbus_dma_arb.sv - QBUS DMR/DMGO/SACK bus-master arbiter for on-board DMA masters
//
// Purpose: requests the bus from the CPU on behalf of NREQ masters, acknowledges
//          the grant, waits for the previous bus cycle to end and hands a
//          one-hot grant to one winner. Every ownership change goes through a
//          full DMR/DMGO handshake.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise fixed
//          priority with index 0 highest and no pointer register.
// Ports:
//   clk     in  1     system clock, posedge
//   dclo_n  in  1     asynchronous active-low reset
//   req     in  NREQ  per-master request level, held for the whole ownership
//   gnt     out NREQ  one-hot grant
//   dmgo_n  in  1     bus grant from CPU, asynchronous, synchronized here
//   sync_n  in  1     bus SYNC, idle detection
//   rply_n  in  1     bus RPLY, idle detection
//   dmr_n   out 1     bus request to CPU
//   sack_n  out 1     grant acknowledge to CPU
//   tmo     out 1     one-cycle pulse when a request is abandoned
module qbus_dma_arb import qbus_pkg::*; #(
  parameter int NREQ = 4,
  parameter int TMO  = TMO_DEFAULT
) (
  input  logic            clk,
  input  logic            dclo_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic            dmgo_n,
  input  logic            sync_n,
  input  logic            rply_n,
  output logic            dmr_n,
  output logic            sack_n,
  output logic            tmo
);

  localparam logic [7:0] TMO_C = 8'(TMO);

  qbus_state_t      state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [NREQ-1:0]  win_q, win_nx, pick, gnt_nx;
  logic             dmr_n_nx, sack_n_nx, tmo_nx;
  logic             dmgo_s1, dmgo_s2;
  logic [IDX_W-1:0] start;
  logic             any_req, dmgo, bus_idle;

  assign any_req  = |req;
  assign dmgo     = ~dmgo_s2;
  // SYNC and RPLY are only used as a level check, so a single sample suffices.
  assign bus_idle = sync_n & rply_n;

  always_ff @(posedge clk or negedge dclo_n) begin
    if (!dclo_n) begin
      dmgo_s1 <= 1'b1;
      dmgo_s2 <= 1'b1;
    end else begin
      dmgo_s1 <= dmgo_n;
      dmgo_s2 <= dmgo_s1;
    end
  end

`ifdef ARB_RR_EN
  logic [IDX_W-1:0] ptr, win_idx;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q[i]) win_idx = IDX_W'(i);
    end
  end

  // ptr holds the first index searched next time: one past the last owner.
  always_ff @(posedge clk or negedge dclo_n) begin
    if (!dclo_n) begin
      ptr <= '0;
    end else if (state == ACK && state_nx == OWN) begin
      ptr <= (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  qbus_arb_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .start (start),
    .win   (pick)
  );

  // Outputs are registered from their next-state values so reset forces them
  // immediately and they never glitch on the CPU pins.
  always_comb begin
    state_nx  = state;
    cnt_nx    = '0;
    win_nx    = win_q;
    gnt_nx    = '0;
    dmr_n_nx  = 1'b1;
    sack_n_nx = 1'b1;
    tmo_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = REQ;
          dmr_n_nx = 1'b0;
        end
      end
      REQ: begin
        // Timeout is checked first so a DMGO landing on the same edge loses.
        if (cnt == TMO_C) begin
          state_nx = IDLE;
          tmo_nx   = 1'b1;
        end else if (dmgo && any_req) begin
          state_nx  = ACK;
          sack_n_nx = 1'b0;
          win_nx    = pick;
        end else if (dmgo) begin
          // Requester vanished: the CPU still needs an acknowledge pulse.
          state_nx  = REL;
          sack_n_nx = 1'b0;
        end else begin
          cnt_nx   = cnt + 8'd1;
          dmr_n_nx = 1'b0;
        end
      end
      ACK: begin
        sack_n_nx = 1'b0;
        if (bus_idle) begin
          state_nx = OWN;
          gnt_nx   = win_q;
        end
      end
      OWN: begin
        sack_n_nx = 1'b0;
        if ((req & win_q) != '0) begin
          gnt_nx = win_q;
        end else begin
          // Grant drops first; SACK is released one cycle later in REL.
          state_nx = REL;
        end
      end
      REL: begin
        if (any_req) begin
          state_nx = REQ;
          dmr_n_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge dclo_n) begin
    if (!dclo_n) begin
      state  <= IDLE;
      cnt    <= '0;
      win_q  <= '0;
      gnt    <= '0;
      dmr_n  <= 1'b1;
      sack_n <= 1'b1;
      tmo    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      win_q  <= win_nx;
      gnt    <= gnt_nx;
      dmr_n  <= dmr_n_nx;
      sack_n <= sack_n_nx;
      tmo    <= tmo_nx;
    end
  end

endmodule

// File: tb/tb_qbus_dma_arb.sv
// tb/tb_qbus_dma_arb.sv - directed self-checking bench for qbus_dma_arb
module tb_qbus_dma_arb;

  logic       clk = 1'b0;
  logic       dclo_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       dmgo_n;
  logic       sync_n;
  logic       rply_n;
  logic       dmr_n;
  logic       sack_n;
  logic       tmo;

  int checks   = 0;
  int failures = 0;

  qbus_dma_arb #(.NREQ(4), .TMO(255)) dut (
    .clk    (clk),
    .dclo_n (dclo_n),
    .req    (req),
    .gnt    (gnt),
    .dmgo_n (dmgo_n),
    .sync_n (sync_n),
    .rply_n (rply_n),
    .dmr_n  (dmr_n),
    .sack_n (sack_n),
    .tmo    (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete ownership: handshake, grant, release.
  task automatic own_cycle(input logic [3:0] exp_gnt, input bit reassert);
    int n;
    n = 0;
    while (dmr_n !== 1'b0 && n < 20) begin step(1); n++; end
    check("own_dmr", 32'(dmr_n), 32'd0);
    dmgo_n = 1'b0;
    n = 0;
    while (sack_n !== 1'b0 && n < 20) begin step(1); n++; end
    check("own_sack", 32'(sack_n), 32'd0);
    check("own_sack_lat", 32'(n), 32'd3);
    dmgo_n = 1'b1;
    step(1);
    check("own_gnt", 32'(gnt), 32'(exp_gnt));
    req = req & ~exp_gnt;
    step(1);
    check("own_gnt_rel", 32'(gnt), 32'd0);
    check("own_sack_rel", 32'(sack_n), 32'd0);
    if (reassert) req = req | exp_gnt;
    step(1);
    check("own_sack_free", 32'(sack_n), 32'd1);
    check("own_dmr_next", 32'(dmr_n), (req != 4'b0000) ? 32'd0 : 32'd1);
  endtask

  initial begin
    dclo_n = 1'b0;
    req    = 4'b0000;
    dmgo_n = 1'b1;
    sync_n = 1'b1;
    rply_n = 1'b1;
    step(2);
    check("rst_dmr", 32'(dmr_n), 32'd1);
    check("rst_sack", 32'(sack_n), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    dclo_n = 1'b1;

    // Single request, DMGO five cycles after the request.
    req = 4'b0100;
    step(1);
    check("single_dmr", 32'(dmr_n), 32'd0);
    check("single_sack_idle", 32'(sack_n), 32'd1);
    step(4);
    dmgo_n = 1'b0;
    step(2);
    check("single_sack_sync", 32'(sack_n), 32'd1);
    step(1);
    check("single_sack", 32'(sack_n), 32'd0);
    check("single_dmr_drop", 32'(dmr_n), 32'd1);
    check("single_gnt_ack", 32'(gnt), 32'd0);
    dmgo_n = 1'b1;
    step(1);
    check("single_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    step(1);
    check("single_gnt_rel", 32'(gnt), 32'd0);
    check("single_sack_rel", 32'(sack_n), 32'd0);
    step(1);
    check("single_sack_free", 32'(sack_n), 32'd1);
    check("single_dmr_idle", 32'(dmr_n), 32'd1);
    step(2);

    // Busy bus: grant waits for SYNC and RPLY both high on one edge.
    req    = 4'b0001;
    sync_n = 1'b0;
    step(1);
    dmgo_n = 1'b0;
    step(3);
    check("busy_sack", 32'(sack_n), 32'd0);
    dmgo_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("busy_gnt_sync", 32'(gnt), 32'd0);
    end
    sync_n = 1'b1;
    rply_n = 1'b0;
    step(2);
    check("busy_gnt_rply", 32'(gnt), 32'd0);
    rply_n = 1'b1;
    step(1);
    check("busy_gnt", 32'(gnt), 32'h1);
    check("busy_sack_own", 32'(sack_n), 32'd0);
    req = 4'b0000;
    step(3);

    // Contention.
`ifdef ARB_RR_EN
    req = 4'b1111;
    own_cycle(4'b0001, 1'b1);
    own_cycle(4'b0010, 1'b1);
    own_cycle(4'b0100, 1'b1);
    own_cycle(4'b1000, 1'b1);
    own_cycle(4'b0001, 1'b0);
    req = 4'b0000;
    step(3);
`else
    req = 4'b1011;
    own_cycle(4'b0001, 1'b0);
    own_cycle(4'b0010, 1'b0);
    own_cycle(4'b1000, 1'b0);
    step(2);
`endif

    // Timeout: DMGO never comes.
    req = 4'b0001;
    step(1);
    check("tmo_dmr", 32'(dmr_n), 32'd0);
    step(255);
    check("tmo_early", 32'(tmo), 32'd0);
    check("tmo_dmr_held", 32'(dmr_n), 32'd0);
    step(1);
    check("tmo_pulse", 32'(tmo), 32'd1);
    check("tmo_dmr_rel", 32'(dmr_n), 32'd1);
    step(1);
    check("tmo_single", 32'(tmo), 32'd0);
    check("tmo_rereq", 32'(dmr_n), 32'd0);
    req = 4'b0000;
    step(3);

    // Vanished request: SACK pulse only, no grant.
    req = 4'b0010;
    step(1);
    check("van_dmr", 32'(dmr_n), 32'd0);
    req    = 4'b0000;
    dmgo_n = 1'b0;
    step(3);
    check("van_sack", 32'(sack_n), 32'd0);
    check("van_gnt", 32'(gnt), 32'd0);
    step(1);
    check("van_sack_free", 32'(sack_n), 32'd1);
    check("van_dmr_idle", 32'(dmr_n), 32'd1);
    check("van_gnt_idle", 32'(gnt), 32'd0);
    dmgo_n = 1'b1;
    step(3);

    // Reset in the middle of an ownership acts without a clock edge.
    req = 4'b0001;
    step(1);
    dmgo_n = 1'b0;
    step(3);
    dmgo_n = 1'b1;
    step(1);
    check("mid_gnt", 32'(gnt), 32'h1);
    #2;
    dclo_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_sack", 32'(sack_n), 32'd1);
    check("mid_rst_dmr", 32'(dmr_n), 32'd1);
    step(2);
    req    = 4'b0000;
    dclo_n = 1'b1;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qbus_dma_arb.md
# qbus_dma_arb

- QBUS bus-master arbiter for the am4 system.
- Collects bus requests from up to NREQ on-board DMA masters, such as the disk DMA and the refresh engine.
- Runs the QBUS DMR/DMGO/SACK handshake with the processor on their behalf, then hands a one-hot grant to one winner.
- Sits between the processor's arbitration pins (pin_dmr_n, pin_dmgo_n, pin_sack_n) and the master-side bus muxes.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TMO, 255: cycles to wait for DMGO before abandoning the request; 8-bit counter.
- clk  in  1  system clock; all logic on posedge.
- dclo_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-master request, active-high level; held for the whole ownership.
- gnt  out  NREQ  one-hot grant, active-high; the master may drive the bus only while its bit is set.
- dmgo_n  in  1  bus grant from the CPU, active-low, asynchronous to clk.
- sync_n  in  1  bus SYNC, active-low, used for idle detection.
- rply_n  in  1  bus RPLY, active-low, used for idle detection.
- dmr_n  out  1  bus request to the CPU, active-low.
- sack_n  out  1  grant acknowledge to the CPU, active-low.
- tmo  out  1  one-cycle pulse when a request is abandoned.

## Operation
- Reset (dclo_n low, asynchronous) forces all outputs to their reset values:
  - dmr_n=1, sack_n=1, gnt=0, tmo=0.
  - State is IDLE, round-robin pointer is 0, timeout counter is 0.
- dmgo_n passes through a 2-flop synchronizer before use. sync_n and rply_n are sampled once per clk, with no synchronizer.
- State machine:
  - IDLE: if |req, go to REQ. dmr_n goes 0 on the same edge.
  - REQ:
    - Counter increments each cycle.
    - Synchronized DMGO low with |req: latch the winner, go to ACK, sack_n=0.
    - Synchronized DMGO low with no req: go to REL and pulse sack_n low for one cycle, because the CPU must see an acknowledge.
    - Counter reaches TMO before DMGO: dmr_n=1, tmo=1 for one cycle, return to IDLE. A new request is allowed on the next cycle.
  - ACK:
    - sack_n=0 and dmr_n=1; DMR is dropped once SACK is asserted.
    - Wait until sync_n=1 and rply_n=1 are sampled on the same edge, meaning the previous bus cycle has finished.
    - Then go to OWN with gnt[winner]=1.
  - OWN: hold gnt and sack_n=0 while req[winner]=1. When req[winner]=0, go to REL; gnt clears on that edge.
  - REL:
    - sack_n=1 and gnt=0 for exactly one cycle.
    - Then go to REQ if |req, otherwise IDLE.
    - Back-to-back masters always re-arbitrate through a full DMR/DMGO handshake.
- Winner selection:
  - Priority is fixed, index 0 highest, unless ARB_RR_EN is defined.
  - The winner is taken from req sampled on the edge that enters ACK.
- Requests from non-winners are ignored until the next arbitration. Changing req during ACK has no effect on the latched winner.
- gnt is never multi-hot. gnt is never set unless sack_n=0.

## Timing
- req rises before edge N: dmr_n=0 after edge N.
- dmgo_n falls: sack_n=0 after the 3rd clk edge (2 synchronizer edges plus 1 FSM edge).
- In ACK with the bus already idle: gnt rises after 1 further edge.
- req[winner] drops before edge M: gnt=0 after M, sack_n=1 after M+1. If req is still pending, dmr_n=0 again after M+1.
- Timeout: tmo pulses on the edge where the counter equals TMO, i.e. TMO+1 cycles after entering REQ. The counter clears on every exit from REQ.
- DMGO arriving on the same edge as the timeout: timeout wins. The late DMGO is answered by the next request, or ignored if no req remains.

## Configuration
- ARB_RR_EN defined:
  - Round-robin arbitration.
  - Search starts at the index after the last winner and wraps NREQ-1 to 0.
  - The pointer updates on entry to OWN.
- ARB_RR_EN undefined:
  - Fixed priority, lowest index wins.
  - No pointer register is built.

## Structure
- Shared package qbus_pkg holds:
  - State encoding localparams: IDLE, REQ, ACK, OWN, REL.
  - Default TMO.
  - Maximum NREQ.
- One sub-module, qbus_arb_pick:
  - Combinational masked priority picker.
  - Inputs: req and start index; output: one-hot winner.
  - Used in both arbitration modes; start index is tied to 0 when ARB_RR_EN is undefined.

## Test plan
- Reset mid-OWN: pull dclo_n low with gnt=0001. Expected: gnt=0, sack_n=1, dmr_n=1 immediately, before any clk edge.
- Single request: req=0100, dmgo_n low 5 cycles later, bus idle. Expected: dmr_n low after 1 edge, sack_n low 3 edges after DMGO, gnt=0100 one edge later. Dropping req gives gnt=0 then sack_n=1.
- Busy bus: sync_n held low 10 cycles after ACK entry. Expected: gnt stays 0 until sync_n=1 and rply_n=1 are sampled together, then gnt asserts on the next edge.
- Contention: req=1011 with fixed priority. Expected grant order: 0001, 0010, 1000, with one REL cycle and a full DMR/DMGO handshake between each. With ARB_RR_EN and req=1111 held, expected order: 0001, 0010, 0100, 1000, 0001.
- Timeout: req=0001 with dmgo_n never asserted, TMO=255. Expected: tmo pulses once, 256 cycles after dmr_n fell, then dmr_n=1. dmr_n=0 again 1 cycle later.
- Vanished request: req=0010 dropped before DMGO arrives. Expected: single-cycle sack_n pulse, gnt stays 0, return to IDLE.
